// File: rtl/red_iterativa_serial_if.sv
// rtl/red_iterativa_serial_if.sv - handshake bundle for the bit-serial iterative cell evaluator
//
// Optional feature macro: ITER_CELLZ_EN (adds the per-cell z capture bus cell_z).
//
// Signals:
//   in_valid  / in_ready / in_data[WIDTH]  word input handshake
//   out_valid / out_ready / out_i / out_z  result output handshake
//   busy                                   evaluator not idle
//   cell_z[WIDTH]                          per-cell z (ITER_CELLZ_EN only)
//
// Modports:
//   master  word producer / result consumer
//   slave   evaluator
interface red_iterativa_serial_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_i;
    logic             out_z;
    logic             busy;
`ifdef ITER_CELLZ_EN
    logic [WIDTH-1:0] cell_z;
`endif

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_i,
        input  out_z,
`ifdef ITER_CELLZ_EN
        input  cell_z,
`endif
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_i,
        output out_z,
`ifdef ITER_CELLZ_EN
        output cell_z,
`endif
        output busy
    );
endinterface

// File: rtl/red_iterativa_serial.sv
// rtl/red_iterativa_serial.sv - bit-serial evaluator of the initial/typical/final iterative cell network
//
// One WIDTH-bit word is shifted through a single registered cell, one bit per
// clock; the final-cell outputs I and Z are returned over a valid/ready
// handshake. Latency: out_valid rises WIDTH-1 clocks after the accept edge.
//
// Parameters:
//   WIDTH      word length / number of cells (>= 2)
//   MSB_FIRST  0: cell k consumes data[k]; 1: cell k consumes data[WIDTH-1-k]
//
// Optional feature macro: ITER_CELLZ_EN (captures z of every cell into cell_z).
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    red_iterativa_serial_if.slave (word in, result out, busy, cell_z)
module red_iterativa_serial #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    red_iterativa_serial_if.slave bus
);

    localparam int                CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   sr_q,    sr_d;
    logic               x_q,     x_d;
    logic               y_q,     y_d;
    logic               r_q,     r_d;
    logic               out_i_q, out_i_d;
    logic               out_z_q, out_z_d;
`ifdef ITER_CELLZ_EN
    logic [WIDTH-1:0]   cell_z_q, cell_z_d;
    logic               typ_z;
`endif

    // Bit fed to the init cell straight from the incoming word, and the bit
    // fed to later cells from the head of the shift register. The register is
    // loaded already advanced by one position, so its head is always the bit
    // for cell cnt.
    logic in_bit;
    logic cur_bit;
    logic fin_z;

    assign in_bit  = MSB_FIRST ? bus.in_data[WIDTH-1] : bus.in_data[0];
    assign cur_bit = MSB_FIRST ? sr_q[WIDTH-1]        : sr_q[0];

    assign fin_z = (x_q & cur_bit) | (r_q & ~cur_bit) | (y_q & ~r_q & cur_bit);
`ifdef ITER_CELLZ_EN
    assign typ_z = ~x_q & y_q & ~r_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        x_d     = x_q;
        y_d     = y_q;
        r_d     = r_q;
        out_i_d = out_i_q;
        out_z_d = out_z_q;
`ifdef ITER_CELLZ_EN
        cell_z_d = cell_z_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sr_d    = MSB_FIRST ? (bus.in_data << 1) : (bus.in_data >> 1);
                    x_d     = in_bit;
                    y_d     = 1'b0;
                    r_d     = ~in_bit;
                    cnt_d   = CNT_ONE;
                    state_d = RUN;
`ifdef ITER_CELLZ_EN
                    cell_z_d = '0;
`endif
                end
            end

            RUN: begin
                sr_d = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
                if (cnt_q == CNT_LAST) begin
                    out_i_d = r_q ^ y_q;
                    out_z_d = fin_z;
                    state_d = DONE;
`ifdef ITER_CELLZ_EN
                    cell_z_d[WIDTH-1] = fin_z;
`endif
                end else begin
                    x_d   = ~x_q & cur_bit & (~r_q | ~y_q);
                    y_d   = (x_q & ~y_q & ~r_q) | (~x_q & y_q & r_q);
                    r_d   = ~cur_bit;
                    cnt_d = cnt_q + CNT_ONE;
`ifdef ITER_CELLZ_EN
                    // z of a typical cell depends only on its incoming state.
                    for (int k = 1; k < WIDTH - 1; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            cell_z_d[k] = typ_z;
                        end
                    end
`endif
                end
            end

            DONE: begin
                // A word offered in this same cycle is not taken; the
                // producer sees in_ready on the following IDLE cycle.
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            r_q     <= 1'b0;
            out_i_q <= 1'b0;
            out_z_q <= 1'b0;
`ifdef ITER_CELLZ_EN
            cell_z_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            x_q     <= x_d;
            y_q     <= y_d;
            r_q     <= r_d;
            out_i_q <= out_i_d;
            out_z_q <= out_z_d;
`ifdef ITER_CELLZ_EN
            cell_z_q <= cell_z_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_i     = out_i_q;
    assign bus.out_z     = out_z_q;
`ifdef ITER_CELLZ_EN
    assign bus.cell_z    = cell_z_q;
`endif

endmodule
